// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the multi-port register bank.
// Optional same-cycle forwarding is enabled with the REG_BANK_BYPASS_EN macro.
package reg_bank_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int ZERO_REG = 0;

    // Read selects carry one extra bit above the register index to reach the PC.
    function automatic int sel_w(input int nreg);
        return $clog2(nreg) + 1;
    endfunction

endpackage

// File: rtl/reg_bank_mp_if.sv
// Bus bundle between the issue/writeback stages and the register bank.
// Used by reg_bank_mp in both builds (REG_BANK_BYPASS_EN defined or not).
interface reg_bank_mp_if
    import reg_bank_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 4,
    parameter int NWR  = 2
);
    localparam int AW = sel_w(NREG);
    localparam int WA = $clog2(NREG);

    // Handshake: wr_en, iss_en and flush are single-cycle strobes sampled on every
    // rising edge; there is no ready, the bank accepts every strobe unconditionally.
    logic [XLEN-1:0]     pc_in;
    logic [NRD*AW-1:0]   rd_sel;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NRD-1:0]      rd_use;
    logic                stall;
    logic [NWR-1:0]      wr_en;
    logic [NWR*WA-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NWR-1:0]      wr_clr;
    logic                iss_en;
    logic [WA-1:0]       iss_rd;
    logic                flush;

    modport master (
        output pc_in, rd_sel, rd_use, wr_en, wr_addr, wr_data, wr_clr,
               iss_en, iss_rd, flush,
        input  rd_data, rd_busy, stall
    );

    modport slave (
        input  pc_in, rd_sel, rd_use, wr_en, wr_addr, wr_data, wr_clr,
               iss_en, iss_rd, flush,
        output rd_data, rd_busy, stall
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set on issue, cleared by retiring writes or a flush.
// Independent of REG_BANK_BYPASS_EN; forwarding only masks busy at the bank's read side.
module reg_scoreboard
    import reg_bank_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NWR  = 2,
    localparam int WA  = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              iss_en_i,
    input  logic [WA-1:0]     iss_rd_i,
    input  logic              flush_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*WA-1:0] wr_addr_i,
    input  logic [NWR-1:0]    wr_clr_i,
    output logic [NREG-1:0]   busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Order matters: flush, then retiring clears, then the issue set, so a new
    // issue always survives both a flush and a clear of the same register.
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end
        for (int w = 0; w < NWR; w++) begin
            if (wr_en_i[w] && wr_clr_i[w]) begin
                busy_d[wr_addr_i[w*WA +: WA]] = 1'b0;
            end
        end
        if (iss_en_i && (iss_rd_i != WA'(ZERO_REG))) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/reg_bank_mp.sv
// Parametrised NRD-read / NWR-write register bank with PC escape and scoreboard.
// Define REG_BANK_BYPASS_EN to forward same-cycle writes to the read ports.
module reg_bank_mp
    import reg_bank_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 4,
    parameter int NWR  = 2
) (
    input logic          clk,
    input logic          reset,
    reg_bank_mp_if.slave bus
);

    localparam int AW = sel_w(NREG);
    localparam int WA = $clog2(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy;

    // Ascending port order makes the highest-index writer win on an address clash.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NWR; w++) begin
            if (bus.wr_en[w] && (bus.wr_addr[w*WA +: WA] != WA'(ZERO_REG))) begin
                regs_d[bus.wr_addr[w*WA +: WA]] = bus.wr_data[w*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR)
    ) u_scoreboard (
        .clk_i     (clk),
        .rst_i     (reset),
        .iss_en_i  (bus.iss_en),
        .iss_rd_i  (bus.iss_rd),
        .flush_i   (bus.flush),
        .wr_en_i   (bus.wr_en),
        .wr_addr_i (bus.wr_addr),
        .wr_clr_i  (bus.wr_clr),
        .busy_o    (busy)
    );

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [AW-1:0]   sel;
        logic [WA-1:0]   idx;
        logic            is_pc;
        logic [XLEN-1:0] val;
        logic            bsy;

        assign sel   = bus.rd_sel[r*AW +: AW];
        assign idx   = sel[WA-1:0];
        assign is_pc = (sel >= AW'(NREG));

        always_comb begin
            val = (idx == WA'(ZERO_REG)) ? '0 : regs_q[idx];
            bsy = busy[idx];
`ifdef REG_BANK_BYPASS_EN
            // A retiring write seen in the same cycle also hides the busy bit it clears.
            for (int w = 0; w < NWR; w++) begin
                if (bus.wr_en[w] && (bus.wr_addr[w*WA +: WA] != WA'(ZERO_REG)) &&
                    (bus.wr_addr[w*WA +: WA] == idx)) begin
                    val = bus.wr_data[w*XLEN +: XLEN];
                    if (bus.wr_clr[w]) begin
                        bsy = 1'b0;
                    end
                end
            end
`endif
            if (is_pc) begin
                val = bus.pc_in;
                bsy = 1'b0;
            end
        end

        assign bus.rd_data[r*XLEN +: XLEN] = val;
        assign bus.rd_busy[r]              = bsy;
    end

    assign bus.stall = |(bus.rd_busy & bus.rd_use);

endmodule

// File: tb/tb_reg_bank_mp.sv
// Self-checking bench for reg_bank_mp: directed vector table, random traffic against
// an array model, and hand sequences for forwarding and asynchronous reset.
module tb_reg_bank_mp;
    import reg_bank_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 4;
    localparam int NWR  = 2;
    localparam int AW   = sel_w(NREG);
    localparam int WA   = $clog2(NREG);
    localparam logic [XLEN-1:0] PC = 32'h100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_bank_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

    reg_bank_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];
    int n_pass  = 0;
    int n_total = 0;

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic int wa_of(input int w);
        return int'(bus.wr_addr[w*WA +: WA]);
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input int s);
        logic [XLEN-1:0] v;
        if (s >= NREG) return bus.pc_in;
        v = (s == 0) ? '0 : m_regs[s];
`ifdef REG_BANK_BYPASS_EN
        for (int w = 0; w < NWR; w++)
            if (bus.wr_en[w] && wa_of(w) != 0 && wa_of(w) == s) v = bus.wr_data[w*XLEN +: XLEN];
`endif
        return v;
    endfunction

    function automatic bit exp_busy(input int s);
        bit b;
        if (s >= NREG || s == 0) return 1'b0;
        b = m_busy[s];
`ifdef REG_BANK_BYPASS_EN
        for (int w = 0; w < NWR; w++)
            if (bus.wr_en[w] && wa_of(w) != 0 && wa_of(w) == s && bus.wr_clr[w]) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic model_commit();
        for (int w = 0; w < NWR; w++)
            if (bus.wr_en[w] && wa_of(w) != 0) m_regs[wa_of(w)] = bus.wr_data[w*XLEN +: XLEN];
        if (bus.flush)
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        for (int w = 0; w < NWR; w++)
            if (bus.wr_en[w] && bus.wr_clr[w]) m_busy[wa_of(w)] = 1'b0;
        if (bus.iss_en && bus.iss_rd != 0) m_busy[int'(bus.iss_rd)] = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input int idx, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h expected %h at %0t", name, idx, act, exp, $time);
    endtask

    task automatic drive_idle();
        bus.pc_in   = PC;
        bus.rd_sel  = '0;
        bus.rd_use  = '0;
        bus.wr_en   = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.wr_clr  = '0;
        bus.iss_en  = 1'b0;
        bus.iss_rd  = '0;
        bus.flush   = 1'b0;
    endtask

    task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d, input bit c);
        bus.wr_en[p]               = 1'b1;
        bus.wr_addr[p*WA +: WA]    = WA'(a);
        bus.wr_data[p*XLEN +: XLEN] = d;
        bus.wr_clr[p]              = c;
    endtask

    function automatic logic [NRD*AW-1:0] pk_sel(input int s0, s1, s2, s3);
        return {AW'(s3), AW'(s2), AW'(s1), AW'(s0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!reset) model_commit();
        #1;
    endtask

    task automatic cycle_model(input string tag);
        logic [NRD-1:0] eb;
        @(negedge clk);
        for (int r = 0; r < NRD; r++) begin
            int s;
            s = int'(bus.rd_sel[r*AW +: AW]);
            eb[r] = exp_busy(s);
            chk({tag, "_data"}, r, bus.rd_data[r*XLEN +: XLEN], exp_rd(s));
            chk({tag, "_busy"}, r, XLEN'(bus.rd_busy[r]), XLEN'(eb[r]));
        end
        chk({tag, "_stall"}, 0, XLEN'(bus.stall), XLEN'(|(eb & bus.rd_use)));
        tick();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [NRD*AW-1:0]   sel;
        logic [NWR-1:0]      wen;
        logic [NWR*WA-1:0]   waddr;
        logic [NWR*XLEN-1:0] wdata;
        logic [NWR-1:0]      wclr;
        logic                iss;
        logic [WA-1:0]       ird;
        logic                fl;
        logic [NRD-1:0]      use_m;
        logic [NRD*XLEN-1:0] xdata;
        logic [NRD-1:0]      xbusy;
        logic                xstall;
    } vec_t;

    function automatic vec_t mkv(input logic [NRD*AW-1:0] sel, input int wen, a0,
                                 input logic [XLEN-1:0] d0, input int a1,
                                 input logic [XLEN-1:0] d1, input int clr, iss, ird, fl, um,
                                 input logic [XLEN-1:0] x0, x1, x2, x3, input int xb, xs);
        vec_t v;
        v.sel = sel; v.wen = NWR'(wen); v.waddr = {WA'(a1), WA'(a0)}; v.wdata = {d1, d0};
        v.wclr = NWR'(clr); v.iss = 1'(iss); v.ird = WA'(ird); v.fl = 1'(fl);
        v.use_m = NRD'(um); v.xdata = {x3, x2, x1, x0}; v.xbusy = NRD'(xb); v.xstall = 1'(xs);
        return v;
    endfunction

    vec_t vecs [10];

    initial begin
        vecs[0] = mkv(pk_sel(0, 5, 31, 32), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, PC, 0, 0);
        vecs[1] = mkv(pk_sel(1, 2, 3, 4), 3, 7, 32'hAAAA, 7, 32'h5555, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2] = mkv(pk_sel(7, 0, 7, 32), 1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 0, 32'h5555, 0, 32'h5555, PC, 0, 0);
        vecs[3] = mkv(pk_sel(0, 7, 1, 63), 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 32'h5555, 0, PC, 0, 0);
        vecs[4] = mkv(pk_sel(3, 3, 0, 33), 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, PC, 4'b0011, 1);
        vecs[5] = mkv(pk_sel(3, 1, 2, 40), 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, PC, 4'b0001, 0);
        vecs[6] = mkv(pk_sel(1, 2, 4, 5), 3, 3, 32'h42, 9, 32'h99, 3, 1, 9, 0, 4'b1111, 0, 0, 0, 0, 0, 0);
        vecs[7] = mkv(pk_sel(3, 9, 9, 3), 0, 0, 0, 0, 0, 0, 1, 4, 1, 4'b1111, 32'h42, 32'h99, 32'h99, 32'h42, 4'b0110, 1);
        vecs[8] = mkv(pk_sel(4, 9, 3, 4), 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h99, 32'h42, 0, 4'b1001, 0);
        vecs[9] = mkv(pk_sel(4, 9, 3, 4), 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 0, 32'h99, 32'h42, 0, 4'b1001, 1);

        drive_idle();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            bus.rd_sel = vecs[i].sel;  bus.wr_en = vecs[i].wen;  bus.wr_addr = vecs[i].waddr;
            bus.wr_data = vecs[i].wdata; bus.wr_clr = vecs[i].wclr; bus.iss_en = vecs[i].iss;
            bus.iss_rd = vecs[i].ird;  bus.flush = vecs[i].fl;  bus.rd_use = vecs[i].use_m;
            bus.pc_in = PC;
            @(negedge clk);
            for (int r = 0; r < NRD; r++)
                chk($sformatf("vec%0d_data", i), r, bus.rd_data[r*XLEN +: XLEN],
                    vecs[i].xdata[r*XLEN +: XLEN]);
            chk($sformatf("vec%0d_busy", i), 0, XLEN'(bus.rd_busy), XLEN'(vecs[i].xbusy));
            chk($sformatf("vec%0d_stall", i), 0, XLEN'(bus.stall), XLEN'(vecs[i].xstall));
            tick();
        end

        // ---------------- random traffic against the model ----------------
        for (int c = 0; c < 400; c++) begin
            bus.pc_in = $urandom;
            for (int r = 0; r < NRD; r++) bus.rd_sel[r*AW +: AW] = AW'($urandom_range(0, 2*NREG-1));
            for (int w = 0; w < NWR; w++) begin
                bus.wr_en[w] = 1'($urandom_range(0, 1));
                bus.wr_addr[w*WA +: WA] = ($urandom_range(0, 1) == 1) ? WA'($urandom_range(0, 7))
                                                                       : WA'($urandom_range(0, NREG-1));
                bus.wr_data[w*XLEN +: XLEN] = $urandom;
                bus.wr_clr[w] = 1'($urandom_range(0, 1));
            end
            bus.iss_en = ($urandom_range(0, 2) == 0);
            bus.iss_rd = WA'($urandom_range(0, 9));
            bus.flush  = ($urandom_range(0, 15) == 0);
            bus.rd_use = NRD'($urandom_range(0, 15));
            cycle_model("rand");
        end

        // ---------------- forwarding corner ----------------
        drive_idle();
        set_wr(0, 12, 32'h0BAD, 1'b0);
        bus.iss_en = 1'b1; bus.iss_rd = WA'(12);
        bus.rd_sel = pk_sel(1, 2, 3, 4);
        cycle_model("byp_pre");

        drive_idle();
        set_wr(0, 12, 32'h1234, 1'b1);
        bus.rd_sel = pk_sel(12, 12, 12, 12);
        bus.rd_use = 4'b0001;
        @(negedge clk);
`ifdef REG_BANK_BYPASS_EN
        chk("byp_same_data", 0, bus.rd_data[XLEN-1:0], 32'h1234);
        chk("byp_same_busy", 0, XLEN'(bus.rd_busy), 32'h0);
        chk("byp_same_stall", 0, XLEN'(bus.stall), 32'h0);
`else
        chk("byp_same_data", 0, bus.rd_data[XLEN-1:0], 32'h0BAD);
        chk("byp_same_busy", 0, XLEN'(bus.rd_busy), 32'hF);
        chk("byp_same_stall", 0, XLEN'(bus.stall), 32'h1);
`endif
        tick();
        drive_idle();
        bus.rd_sel = pk_sel(12, 12, 12, 12);
        bus.rd_use = 4'b0001;
        @(negedge clk);
        chk("byp_next_data", 0, bus.rd_data[XLEN-1:0], 32'h1234);
        chk("byp_next_busy", 0, XLEN'(bus.rd_busy), 32'h0);
        chk("byp_next_stall", 0, XLEN'(bus.stall), 32'h0);
        tick();

        // ---------------- asynchronous reset between edges ----------------
        drive_idle();
        set_wr(0, 6, 32'hABCD, 1'b0);
        bus.iss_en = 1'b1; bus.iss_rd = WA'(5);
        cycle_model("ar_pre");

        drive_idle();
        bus.rd_sel = pk_sel(6, 5, 8, 40);
        bus.rd_use = 4'b0010;
        set_wr(1, 8, 32'h7777, 1'b0);
        @(negedge clk);
        chk("ar_hold_data", 0, bus.rd_data[XLEN-1:0], 32'hABCD);
        chk("ar_hold_busy", 1, XLEN'(bus.rd_busy[1]), 32'h1);
        chk("ar_hold_stall", 0, XLEN'(bus.stall), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("ar_now_data", 0, bus.rd_data[XLEN-1:0], 32'h0);
        chk("ar_now_busy", 1, XLEN'(bus.rd_busy[1]), 32'h0);
        chk("ar_now_stall", 0, XLEN'(bus.stall), 32'h0);
        chk("ar_now_pc", 3, bus.rd_data[3*XLEN +: XLEN], PC);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        drive_idle();
        bus.rd_sel = pk_sel(8, 6, 5, 0);
        bus.rd_use = 4'b1111;
        cycle_model("ar_post");

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
